// File: rtl/adder_subtractor.sv
// Registered two's-complement adder/subtractor: ripple-carry chain fed by a
// B-inversion stage, with carry-out and signed-overflow flags and a one-cycle latency.
module adder_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             V,
  output logic             out_valid
);

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] sum;
  logic [WIDTH:0]   carry;

  logic [WIDTH-1:0] s_d, s_q;
  logic             cout_d, cout_q;
  logic             v_d, v_q;
  logic             out_valid_d, out_valid_q;

  // Cin doubles as the subtract select: inverting B and injecting a carry of 1 gives A + ~B + 1.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_binv
      assign b_eff[gi] = B[gi] ^ Cin;
    end
  endgenerate

  always_comb begin
    carry    = '0;
    sum      = '0;
    carry[0] = Cin;
    for (int i = 0; i < WIDTH; i++) begin
      sum[i]       = A[i] ^ b_eff[i] ^ carry[i];
      carry[i+1]   = (A[i] & b_eff[i]) | (A[i] & carry[i]) | (b_eff[i] & carry[i]);
    end
  end

  always_comb begin
    s_d         = s_q;
    cout_d      = cout_q;
    v_d         = v_q;
    out_valid_d = 1'b0;
    if (in_valid) begin
      s_d         = sum;
      cout_d      = carry[WIDTH];
      v_d         = carry[WIDTH] ^ carry[WIDTH-1];
      out_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_q         <= '0;
      cout_q      <= 1'b0;
      v_q         <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      s_q         <= s_d;
      cout_q      <= cout_d;
      v_q         <= v_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign S         = s_q;
  assign Cout      = cout_q;
  assign V         = v_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_adder_subtractor.sv
// Scoreboard bench for adder_subtractor at WIDTH=4 (directed, random, exhaustive)
// and WIDTH=8 (directed plus an edge-value subset).
module tb_adder_subtractor;

  typedef struct packed {
    logic [7:0] s;
    logic       c;
    logic       v;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       in_valid4, Cin4, Cout4, V4, out_valid4;
  logic [3:0] A4, B4, S4;
  logic       in_valid8, Cin8, Cout8, V8, out_valid8;
  logic [7:0] A8, B8, S8;

  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 0;
  exp_t q4[$];
  exp_t q8[$];
  exp_t last4, last8;

  adder_subtractor #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .A(A4), .B(B4), .Cin(Cin4),
    .S(S4), .Cout(Cout4), .V(V4), .out_valid(out_valid4)
  );

  adder_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .A(A8), .B(B8), .Cin(Cin8),
    .S(S8), .Cout(Cout8), .V(V8), .out_valid(out_valid8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [7:0] s, input logic c, input logic v);
    exp_t e;
    e.s = s;
    e.c = c;
    e.v = v;
    return e;
  endfunction

  // Arithmetic reference: integer add/subtract, unsigned compare for borrow, sign rules for overflow.
  function automatic exp_t model(input int w, input int a, input int b, input bit cin);
    exp_t e;
    int   mask;
    int   r;
    int   sa, sb, sr;
    mask = (1 << w) - 1;
    r    = cin ? (a - b) : (a + b);
    r    = r & mask;
    sa   = (a >> (w - 1)) & 1;
    sb   = (b >> (w - 1)) & 1;
    sr   = (r >> (w - 1)) & 1;
    e.s  = 8'(r);
    e.c  = cin ? (a >= b) : ((((a + b) >> w) & 1) != 0);
    e.v  = cin ? ((sa != sb) && (sr != sa)) : ((sa == sb) && (sr != sa));
    return e;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic issue4(input logic [3:0] a, input logic [3:0] b, input logic cin, input exp_t e);
    @(posedge clk);
    #1;
    in_valid4 = 1'b1;
    A4 = a; B4 = b; Cin4 = cin;
    q4.push_back(e);
    $display("issue4 A=%h B=%h Cin=%0d exp S=%h C=%0d V=%0d", a, b, cin, e.s, e.c, e.v);
  endtask

  task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic cin, input exp_t e);
    @(posedge clk);
    #1;
    in_valid8 = 1'b1;
    A8 = a; B8 = b; Cin8 = cin;
    q8.push_back(e);
    $display("issue8 A=%h B=%h Cin=%0d exp S=%h C=%0d V=%0d", a, b, cin, e.s, e.c, e.v);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      in_valid4 = 1'b0;
      in_valid8 = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (out_valid4 === 1'b1) begin
        if (q4.size() == 0) begin
          chk("unexpected_out4", 8'd1, 8'd0);
        end else begin
          exp_t e;
          e = q4.pop_front();
          chk("s4", {4'b0, S4}, e.s);
          chk("cout4", {7'b0, Cout4}, {7'b0, e.c});
          chk("v4", {7'b0, V4}, {7'b0, e.v});
          last4 = e;
        end
      end else begin
        chk("out_valid4_low", {7'b0, out_valid4}, 8'd0);
        chk("hold_s4", {4'b0, S4}, last4.s);
        chk("hold_flags4", {6'b0, Cout4, V4}, {6'b0, last4.c, last4.v});
      end
      if (out_valid8 === 1'b1) begin
        if (q8.size() == 0) begin
          chk("unexpected_out8", 8'd1, 8'd0);
        end else begin
          exp_t e;
          e = q8.pop_front();
          chk("s8", S8, e.s);
          chk("cout8", {7'b0, Cout8}, {7'b0, e.c});
          chk("v8", {7'b0, V8}, {7'b0, e.v});
          last8 = e;
        end
      end else begin
        chk("out_valid8_low", {7'b0, out_valid8}, 8'd0);
        chk("hold_s8", S8, last8.s);
        chk("hold_flags8", {6'b0, Cout8, V8}, {6'b0, last8.c, last8.v});
      end
    end
  end

  initial begin
    logic [7:0] edge_vals [8];
    logic [3:0] ra, rb;
    edge_vals = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'hFF, 8'h55, 8'hAA, 8'h3C};
    last4 = mk(8'h00, 1'b0, 1'b0);
    last8 = mk(8'h00, 1'b0, 1'b0);

    // Reset wins over a valid request presented alongside it.
    rst = 1'b1;
    in_valid4 = 1'b1; A4 = 4'b0101; B4 = 4'b0011; Cin4 = 1'b0;
    in_valid8 = 1'b1; A8 = 8'h7F;   B8 = 8'h01;   Cin8 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_s4", {4'b0, S4}, 8'h00);
    chk("rst_flags4", {6'b0, Cout4, V4}, 8'h00);
    chk("rst_out_valid4", {7'b0, out_valid4}, 8'h00);
    chk("rst_s8", S8, 8'h00);
    chk("rst_out_valid8", {7'b0, out_valid8}, 8'h00);
    rst = 1'b0;
    in_valid4 = 1'b0;
    in_valid8 = 1'b0;
    mon_en = 1'b1;

    issue4(4'b0101, 4'b0011, 1'b0, mk(8'b1000, 1'b0, 1'b1));
    issue4(4'b1111, 4'b0001, 1'b0, mk(8'b0000, 1'b1, 1'b0));
    issue4(4'b0011, 4'b0101, 1'b1, mk(8'b1110, 1'b0, 1'b0));
    issue4(4'b1000, 4'b0001, 1'b1, mk(8'b0111, 1'b1, 1'b1));
    issue4(4'b0000, 4'b0000, 1'b1, mk(8'b0000, 1'b1, 1'b0));
    issue4(4'b0111, 4'b1111, 1'b1, mk(8'b1000, 1'b0, 1'b1));
    idle(2);

    for (int i = 0; i < 10; i++) begin
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 15));
      issue4(ra, rb, 1'(i % 2), model(4, int'(ra), int'(rb), 1'(i % 2)));
    end
    idle(3);

    for (int c = 0; c < 2; c++)
      for (int a = 0; a < 16; a++)
        for (int b = 0; b < 16; b++)
          issue4(4'(a), 4'(b), 1'(c), model(4, a, b, 1'(c)));
    idle(2);

    issue8(8'h7F, 8'h01, 1'b0, mk(8'h80, 1'b0, 1'b1));
    issue8(8'h00, 8'h01, 1'b1, mk(8'hFF, 1'b0, 1'b0));
    issue8(8'hFF, 8'hFF, 1'b0, mk(8'hFE, 1'b1, 1'b0));
    issue8(8'h80, 8'h7F, 1'b1, mk(8'h01, 1'b1, 1'b1));
    for (int c = 0; c < 2; c++)
      for (int a = 0; a < 8; a++)
        for (int b = 0; b < 8; b++)
          issue8(edge_vals[a], edge_vals[b], 1'(c),
                 model(8, int'(edge_vals[a]), int'(edge_vals[b]), 1'(c)));
    idle(3);

    for (int i = 0; i < 20 && (q4.size() != 0 || q8.size() != 0); i++) @(negedge clk);
    chk("drain4", 8'(q4.size()), 8'd0);
    chk("drain8", 8'(q8.size()), 8'd0);
    @(negedge clk);
    mon_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
